// File: rtl/con_bus_scheduler.sv
// Time-shares the bidirectional con buses between the load (inbound) and
// drain (outbound) requesters: whole-burst grants, beat counting, bus turnaround.
module con_bus_scheduler #(
  parameter int LEN_WIDTH         = 8,
  parameter int TURNAROUND_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 load_req,
  input  logic [LEN_WIDTH-1:0] load_len,
  output logic                 load_grant,
  output logic                 load_beat,
  output logic                 load_done,
  input  logic                 drain_req,
  input  logic [LEN_WIDTH-1:0] drain_len,
  output logic                 drain_grant,
  output logic                 drain_beat,
  output logic                 drain_done,
  output logic [LEN_WIDTH-1:0] beat_idx,
  input  logic                 con_valid,
  output logic                 con_ready,
  output logic                 output_valid,
  output logic                 driving_cons,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, LOAD, TURN_DRV, DRAIN, TURN_RCV} state_t;

  localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);
  localparam logic [2:0]           TA_LAST = 3'(TURNAROUND_CYCLES - 1);
  localparam bit                   HAS_TA  = (TURNAROUND_CYCLES != 0);

  state_t               state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] idx_q;
  logic [2:0]           turn_cnt;
  logic                 prio_load;

  logic zero_len, last_beat;
  assign zero_len  = (len_q == '0);
  assign last_beat = (idx_q == len_q - ONE);

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state     <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      turn_cnt  <= '0;
      prio_load <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          idx_q    <= '0;
          turn_cnt <= '0;
          if (load_req && (prio_load || !drain_req)) begin
            state     <= LOAD;
            len_q     <= load_len;
            prio_load <= 1'b0;
          end else if (drain_req) begin
            len_q     <= drain_len;
            prio_load <= 1'b1;
            // a zero-length drain never turns the bus around
            state     <= (HAS_TA && drain_len != '0) ? TURN_DRV : DRAIN;
          end
        end
        LOAD: begin
          if (zero_len) begin
            state <= IDLE;
          end else if (con_valid) begin
            if (last_beat) begin
              state <= IDLE;
              idx_q <= '0;
            end else begin
              idx_q <= idx_q + ONE;
            end
          end
        end
        TURN_DRV: begin
          if (turn_cnt == TA_LAST) begin
            turn_cnt <= '0;
            state    <= DRAIN;
          end else begin
            turn_cnt <= turn_cnt + 3'd1;
          end
        end
        DRAIN: begin
          if (zero_len) begin
            state <= IDLE;
          end else if (last_beat) begin
            idx_q    <= '0;
            turn_cnt <= '0;
            state    <= HAS_TA ? TURN_RCV : IDLE;
          end else begin
            idx_q <= idx_q + ONE;
          end
        end
        TURN_RCV: begin
          if (turn_cnt == TA_LAST) begin
            turn_cnt <= '0;
            state    <= IDLE;
          end else begin
            turn_cnt <= turn_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode purely from registered state/counters (plus con_valid for beats).
  assign load_grant   = (state == LOAD);
  assign con_ready    = load_grant && !zero_len;
  assign load_beat    = con_ready && con_valid;
  assign load_done    = load_grant && (zero_len || (con_valid && last_beat));
  assign drain_grant  = (state == DRAIN);
  assign driving_cons = drain_grant && !zero_len;
  assign output_valid = driving_cons;
  assign drain_beat   = driving_cons;
  assign drain_done   = drain_grant && (zero_len || last_beat);
  assign beat_idx     = idx_q;
  assign busy         = (state != IDLE);

endmodule
